// File: rtl/cbus_axi_bridge_if.sv
// Bus payload types for the cache-side $Bus, plus the cache-side and AXI3
// interfaces used by cbus_axi_bridge.
package cbus_axi_bridge_pkg;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ORDER_W = 3;

  typedef struct packed {
    logic                valid;
    logic                is_write;
    logic [ORDER_W-1:0]  order;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
  } cbus_req_t;

  typedef struct packed {
    logic                okay;
    logic                last;
    logic [DATA_W-1:0]   rdata;
  } cbus_resp_t;
endpackage

interface cbus_if;
  import cbus_axi_bridge_pkg::*;
  cbus_req_t  req;
  cbus_resp_t resp;

  modport master (output req, input resp);
  modport slave  (input req, output resp);
endinterface

interface axi_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rlast;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rdata, rlast, rresp, rvalid, output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bresp, bvalid, output bready
  );
  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rdata, rlast, rresp, rvalid, input rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bresp, bvalid, input bready
  );
endinterface

// File: rtl/cbus_axi_bridge.sv
// Turns one cache line refill / write-back on the $Bus into a single AXI3 INCR
// burst; one transaction outstanding at a time.
module cbus_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'h0
) (
  input  logic   clk,
  input  logic   reset,
  cbus_if.slave  cbus,
  axi_if.master  axi
);
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned ADDR_W = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AR   = 3'd1,
    R    = 3'd2,
    AW   = 3'd3,
    W    = 3'd4,
    B    = 3'd5
  } state_t;

  state_t             state;
  logic [LEN_W-1:0]   beat;
  logic [LEN_W-1:0]   len;
  logic [ADDR_W-1:0]  addr;
  logic               arvalid_q, rready_q, awvalid_q, wvalid_q, wlast_q, bready_q;

  logic [LEN_W-1:0]   len_c;
  logic               at_last_c;
  logic               okay_c;
  logic               unused_axi;

  assign len_c     = LEN_W'((5'd1 << cbus.req.order) - 5'd1);
  assign at_last_c = (beat == len);

  // Per-beat handshake reported straight back to the cache with no added latency.
  assign okay_c = ((state == R) && axi.rvalid) || ((state == W) && axi.wready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      beat      <= '0;
      len       <= '0;
      addr      <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cbus.req.valid) begin
            addr <= cbus.req.addr;
            len  <= len_c;
            beat <= '0;
            if (cbus.req.is_write) begin
              state     <= AW;
              awvalid_q <= 1'b1;
            end else begin
              state     <= AR;
              arvalid_q <= 1'b1;
            end
          end
        end
        AR: begin
          if (axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= R;
          end
        end
        R: begin
          // Beat counter decides the end of burst; rlast is ignored.
          if (axi.rvalid) begin
            beat <= beat + 4'd1;
            if (at_last_c) begin
              rready_q <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        AW: begin
          if (axi.awready) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            wlast_q   <= (len == '0);
            state     <= W;
          end
        end
        W: begin
          if (axi.wready) begin
            beat <= beat + 4'd1;
            if (at_last_c) begin
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              bready_q <= 1'b1;
              state    <= B;
            end else begin
              wlast_q <= ((beat + 4'd1) == len);
            end
          end
        end
        B: begin
          if (axi.bvalid) begin
            bready_q <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign axi.arid    = AXI_ID;
  assign axi.araddr  = addr;
  assign axi.arlen   = len;
  assign axi.arsize  = 3'b010;
  assign axi.arburst = 2'b01;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

  assign axi.awid    = AXI_ID;
  assign axi.awaddr  = addr;
  assign axi.awlen   = len;
  assign axi.awsize  = 3'b010;
  assign axi.awburst = 2'b01;
  assign axi.awvalid = awvalid_q;

  assign axi.wdata   = cbus.req.wdata;
  assign axi.wstrb   = 4'hF;
  assign axi.wlast   = wlast_q;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;

  assign cbus.resp.okay  = okay_c;
  assign cbus.resp.last  = okay_c && at_last_c;
  assign cbus.resp.rdata = axi.rdata;

  assign unused_axi = ^{axi.rlast, axi.rresp, axi.bresp};
endmodule

// File: tb/tb_cbus_axi_bridge.sv
// Self-checking bench for cbus_axi_bridge: table of bursts plus hand-written
// back-to-back and mid-burst reset sequences, with a scoreboard on each beat.
module tb_cbus_axi_bridge;
  import cbus_axi_bridge_pkg::*;

  localparam logic [3:0]  TB_ID = 4'h3;
  localparam logic [31:0] WBASE = 32'hA500_0000;

  logic clk;
  logic reset;

  cbus_if cb ();
  axi_if  ax ();

  cbus_axi_bridge #(.AXI_ID(TB_ID)) dut (
    .clk   (clk),
    .reset (reset),
    .cbus  (cb),
    .axi   (ax)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_write;
    logic [2:0]  order;
    logic [31:0] addr;
    int          delay;      // AR/AW ready delay in cycles
    int          stall_at;   // R beat index before which rvalid drops
    int          stall_len;
    bit          toggle;     // wready alternates 1/0
    int          b_delay;
    logic [3:0]  exp_len;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_ar_hs  = 0;
  int   n_aw_hs  = 0;

  always @(posedge clk) begin
    if (!reset && ax.arvalid && ax.arready) n_ar_hs <= n_ar_hs + 1;
    if (!reset && ax.awvalid && ax.awready) n_aw_hs <= n_aw_hs + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pop_expect(output exp_t e, output bit ok);
    ok = (sb.size() > 0);
    if (ok) e = sb.pop_front();
    else chk("scoreboard_underflow", 32'd1, 32'd0);
  endtask

  task automatic check_addr_phase(input vec_t v, input bit wr);
    if (wr) begin
      chk("awaddr", ax.awaddr, v.addr);
      chk("awlen", 32'(ax.awlen), 32'(v.exp_len));
      chk("awsize", 32'(ax.awsize), 32'd2);
      chk("awburst", 32'(ax.awburst), 32'd1);
      chk("awid", 32'(ax.awid), 32'(TB_ID));
    end else begin
      chk("araddr", ax.araddr, v.addr);
      chk("arlen", 32'(ax.arlen), 32'(v.exp_len));
      chk("arsize", 32'(ax.arsize), 32'd2);
      chk("arburst", 32'(ax.arburst), 32'd1);
      chk("arid", 32'(ax.arid), 32'(TB_ID));
    end
  endtask

  task automatic do_read(input vec_t v, input bit pre_issued);
    int   n_ok = 0;
    int   n    = 0;
    int   stall_left;
    bit   got  = 0;
    exp_t e;
    bit   ok;
    stall_left = v.stall_len;
    if (!pre_issued) begin
      cb.req.valid = 1'b1; cb.req.is_write = 1'b0;
      cb.req.order = v.order; cb.req.addr = v.addr;
      @(posedge clk); @(negedge clk);
      cb.req.valid = 1'b0;
      #1 chk("arvalid_t1", 32'(ax.arvalid), 32'd1);
    end else begin
      for (int i = 0; i < 50 && !got; i++) begin
        @(negedge clk); #1;
        if (ax.arvalid) got = 1;
      end
      cb.req.valid = 1'b0;
      chk("arvalid_wait", 32'(got), 32'd1);
    end
    check_addr_phase(v, 1'b0);
    chk("awvalid_in_read", 32'(ax.awvalid), 32'd0);
    for (int i = 0; i < v.delay; i++) begin
      @(posedge clk); @(negedge clk); #1;
      chk("arvalid_hold", 32'(ax.arvalid), 32'd1);
    end
    ax.arready = 1'b1;
    @(posedge clk); @(negedge clk);
    ax.arready = 1'b0;
    for (int cyc = 0; cyc < 100 && n <= int'(v.exp_len); cyc++) begin
      if (n == v.stall_at && stall_left > 0) begin
        stall_left--;
        ax.rvalid = 1'b0; ax.rdata = 32'hDEAD_0000;
      end else begin
        ax.rvalid = 1'b1; ax.rdata = 32'(n);
        sb.push_back('{data: 32'(n), last: (n == int'(v.exp_len))});
        n++;
      end
      #1;
      chk("rready", 32'(ax.rready), 32'd1);
      chk("r_okay", 32'(cb.resp.okay), 32'(ax.rvalid));
      if (cb.resp.okay) begin
        n_ok++;
        pop_expect(e, ok);
        if (ok) begin
          chk("r_rdata", cb.resp.rdata, e.data);
          chk("r_last", 32'(cb.resp.last), 32'(e.last));
        end
      end else begin
        chk("r_last_idle", 32'(cb.resp.last), 32'd0);
      end
      @(posedge clk); @(negedge clk);
    end
    ax.rvalid = 1'b0;
    #1;
    chk("r_beats", 32'(n_ok), 32'(v.exp_len) + 32'd1);
    chk("rready_after", 32'(ax.rready), 32'd0);
    chk("arvalid_after", 32'(ax.arvalid), 32'd0);
    sb.delete();
  endtask

  task automatic do_write(input vec_t v, input bit hold, input logic [31:0] next_addr,
                          input int abort_at);
    int   w = 0;
    exp_t e;
    bit   ok;
    cb.req.valid = 1'b1; cb.req.is_write = 1'b1;
    cb.req.order = v.order; cb.req.addr = v.addr; cb.req.wdata = WBASE;
    @(posedge clk); @(negedge clk);
    if (!hold) cb.req.valid = 1'b0;
    #1 chk("awvalid_t1", 32'(ax.awvalid), 32'd1);
    chk("arvalid_in_write", 32'(ax.arvalid), 32'd0);
    check_addr_phase(v, 1'b1);
    for (int i = 0; i < v.delay; i++) begin
      @(posedge clk); @(negedge clk); #1;
      chk("awvalid_hold", 32'(ax.awvalid), 32'd1);
    end
    ax.awready = 1'b1;
    @(posedge clk); @(negedge clk);
    ax.awready = 1'b0;
    for (int cyc = 0; cyc < 200 && w <= int'(v.exp_len); cyc++) begin
      cb.req.wdata = WBASE + 32'(w);
      ax.wready    = v.toggle ? ((cyc % 2) == 0) : 1'b1;
      if (ax.wready) sb.push_back('{data: WBASE + 32'(w), last: (w == int'(v.exp_len))});
      #1;
      chk("wvalid", 32'(ax.wvalid), 32'd1);
      chk("w_okay", 32'(cb.resp.okay), 32'(ax.wready));
      if (abort_at == w && ax.wready) begin
        reset = 1'b1;
        #1;
        chk("rst_awvalid", 32'(ax.awvalid), 32'd0);
        chk("rst_wvalid", 32'(ax.wvalid), 32'd0);
        chk("rst_wlast", 32'(ax.wlast), 32'd0);
        chk("rst_bready", 32'(ax.bready), 32'd0);
        chk("rst_arvalid", 32'(ax.arvalid), 32'd0);
        chk("rst_rready", 32'(ax.rready), 32'd0);
        chk("rst_okay", 32'(cb.resp.okay), 32'd0);
        chk("rst_last", 32'(cb.resp.last), 32'd0);
        chk("rst_awaddr", ax.awaddr, 32'd0);
        chk("rst_awlen", 32'(ax.awlen), 32'd0);
        ax.wready = 1'b0; cb.req.valid = 1'b0;
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      if (cb.resp.okay) begin
        pop_expect(e, ok);
        if (ok) begin
          chk("w_wdata", ax.wdata, e.data);
          chk("w_wlast", 32'(ax.wlast), 32'(e.last));
          chk("w_last", 32'(cb.resp.last), 32'(e.last));
        end
        w++;
      end
      @(posedge clk); @(negedge clk);
    end
    chk("w_beats", 32'(w), 32'(v.exp_len) + 32'd1);
    ax.wready = 1'b0;
    if (hold) begin
      cb.req.valid = 1'b1; cb.req.is_write = 1'b0;
      cb.req.order = 3'd4; cb.req.addr = next_addr;
    end else begin
      cb.req.valid = 1'b0;
    end
    ax.bvalid = (v.b_delay == 0);
    #1;
    chk("bready_enter", 32'(ax.bready), 32'd1);
    chk("wvalid_after", 32'(ax.wvalid), 32'd0);
    chk("wlast_after", 32'(ax.wlast), 32'd0);
    for (int i = 0; i < v.b_delay; i++) begin
      @(posedge clk); @(negedge clk);
      ax.bvalid = (i == v.b_delay - 1);
      #1;
      chk("bready_hold", 32'(ax.bready), 32'd1);
      chk("arvalid_in_b", 32'(ax.arvalid), 32'd0);
    end
    @(posedge clk); @(negedge clk);
    ax.bvalid = 1'b0;
    #1;
    chk("bready_after", 32'(ax.bready), 32'd0);
    chk("arvalid_after_b", 32'(ax.arvalid), 32'd0);
    chk("awvalid_after_b", 32'(ax.awvalid), 32'd0);
    sb.delete();
  endtask

  vec_t vecs[7];
  vec_t refill_b2b;

  initial begin
    int ar0, aw0;
    vecs[0] = '{1'b0, 3'd4, 32'h1FC0_0040, 2, -1, 0, 1'b0, 0, 4'd15};
    vecs[1] = '{1'b1, 3'd4, 32'h0000_1000, 0, -1, 0, 1'b1, 2, 4'd15};
    vecs[2] = '{1'b0, 3'd0, 32'h0000_0080, 0, -1, 0, 1'b0, 0, 4'd0};
    vecs[3] = '{1'b0, 3'd4, 32'h0000_2000, 1,  6, 5, 1'b0, 0, 4'd15};
    vecs[4] = '{1'b1, 3'd2, 32'h0000_3000, 1, -1, 0, 1'b0, 0, 4'd3};
    vecs[5] = '{1'b0, 3'd1, 32'h0000_4000, 0, -1, 0, 1'b0, 0, 4'd1};
    vecs[6] = '{1'b1, 3'd0, 32'h0000_5000, 0, -1, 0, 1'b1, 1, 4'd0};
    refill_b2b = '{1'b0, 3'd4, 32'h0000_6000, 1, -1, 0, 1'b0, 0, 4'd15};

    reset = 1'b1;
    cb.req = '0;
    ax.arready = 1'b0; ax.rdata = '0; ax.rlast = 1'b0; ax.rresp = 2'b00; ax.rvalid = 1'b0;
    ax.awready = 1'b0; ax.wready = 1'b0; ax.bresp = 2'b00; ax.bvalid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_arvalid", 32'(ax.arvalid), 32'd0);
    chk("reset_awvalid", 32'(ax.awvalid), 32'd0);
    chk("reset_wvalid", 32'(ax.wvalid), 32'd0);
    chk("reset_rready", 32'(ax.rready), 32'd0);
    chk("reset_bready", 32'(ax.bready), 32'd0);
    chk("reset_wlast", 32'(ax.wlast), 32'd0);
    chk("reset_okay", 32'(cb.resp.okay), 32'd0);
    chk("reset_araddr", ax.araddr, 32'd0);
    chk("reset_arlen", 32'(ax.arlen), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].is_write) do_write(vecs[i], 1'b0, 32'd0, -1);
      else                  do_read(vecs[i], 1'b0);
      @(negedge clk);
    end

    // Write-back then refill with valid held high throughout.
    ar0 = n_ar_hs; aw0 = n_aw_hs;
    do_write(vecs[1], 1'b1, refill_b2b.addr, -1);
    do_read(refill_b2b, 1'b1);
    @(negedge clk);
    chk("b2b_ar_count", 32'(n_ar_hs - ar0), 32'd1);
    chk("b2b_aw_count", 32'(n_aw_hs - aw0), 32'd1);

    // Reset during the 7th write beat, then a normal refill.
    do_write(vecs[1], 1'b0, 32'd0, 6);
    @(negedge clk);
    do_read(vecs[0], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
